// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider.
// Define MDU_EARLY_OUT_EN to let MUL stop once the remaining multiplier bits are zero.
module mdu_iterative #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic            div_by_zero
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MIN  = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state;
   logic [2:0]          op_q;
   logic [CNT_W-1:0]    cnt;
   logic                neg;
   logic [2*XLEN-1:0]   acc;
   logic [2*XLEN-1:0]   mc;
   logic [XLEN-1:0]     mp;
   logic [XLEN-1:0]     q;
   logic [XLEN-1:0]     d;
   logic [XLEN-1:0]     r;
   logic [XLEN-1:0]     res_q;
   logic                dbz_q;

   logic                sa_en, sb_en, sa, sb;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                b_zero, ovf;
   logic [XLEN:0]       div_sh, div_tr;
   logic [2*XLEN-1:0]   mul_add, prod;
   logic [XLEN-1:0]     quo, rem_v, fix_res;
   logic                mul_last;

   assign sa_en  = (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b110);
   assign sb_en  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
   assign sa     = sa_en & operand_a[XLEN-1];
   assign sb     = sb_en & operand_b[XLEN-1];
   assign mag_a  = sa ? -operand_a : operand_a;
   assign mag_b  = sb ? -operand_b : operand_b;
   assign b_zero = (operand_b == '0);
   assign ovf    = op[2] && !op[0] && (operand_a == MIN) &&
                   (operand_b == '1);

   assign div_sh  = {r, q[XLEN-1]};
   assign div_tr  = div_sh - {1'b0, d};
   assign mul_add = acc + (mp[0] ? mc : '0);

`ifdef MDU_EARLY_OUT_EN
   assign mul_last = (cnt == LAST) || (mp[XLEN-1:1] == '0);
`else
   assign mul_last = (cnt == LAST);
`endif

   assign prod  = neg ? -acc : acc;
   assign quo   = neg ? -q : q;
   assign rem_v = neg ? -r : r;

   always_comb begin
      fix_res = '0;
      if (op_q[2])
         fix_res = op_q[1] ? rem_v : quo;
      else if (op_q[1:0] == 2'b00)
         fix_res = prod[XLEN-1:0];
      else
         fix_res = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         op_q         <= '0;
         cnt          <= '0;
         neg          <= 1'b0;
         acc          <= '0;
         mc           <= '0;
         mp           <= '0;
         q            <= '0;
         d            <= '0;
         r            <= '0;
         res_q        <= '0;
         dbz_q        <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         div_by_zero  <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         div_by_zero  <= 1'b0;
         if (state != IDLE && flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !flush) begin
                     op_q  <= op;
                     cnt   <= '0;
                     neg   <= (op[2] && op[1]) ? sa : (sa ^ sb);
                     acc   <= '0;
                     mc    <= {{XLEN{1'b0}}, mag_a};
                     mp    <= mag_b;
                     q     <= mag_a;
                     d     <= mag_b;
                     r     <= '0;
                     dbz_q <= 1'b0;
                     if (op[2] && b_zero) begin
                        res_q <= op[1] ? operand_a : '1;
                        dbz_q <= 1'b1;
                        state <= DONE;
                     end else if (ovf) begin
                        res_q <= op[1] ? '0 : operand_a;
                        state <= DONE;
                     end else begin
                        state <= op[2] ? DIV : MUL;
                        busy  <= 1'b1;
                     end
                  end
               end
               MUL: begin
                  acc <= mul_add;
                  mc  <= mc << 1;
                  mp  <= mp >> 1;
                  cnt <= cnt + CNT_W'(1);
                  if (mul_last) state <= FIX;
               end
               DIV: begin
                  if (!div_tr[XLEN]) begin
                     r <= div_tr[XLEN-1:0];
                     q <= {q[XLEN-2:0], 1'b1};
                  end else begin
                     r <= div_sh[XLEN-1:0];
                     q <= {q[XLEN-2:0], 1'b0};
                  end
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) state <= FIX;
               end
               FIX: begin
                  res_q <= fix_res;
                  busy  <= 1'b0;
                  state <= DONE;
               end
               DONE: begin
                  result       <= res_q;
                  result_valid <= 1'b1;
                  div_by_zero  <= dbz_q;
                  state        <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative (default build, XLEN=32).
module tb_mdu_iterative;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, result_valid, div_by_zero;
   logic [31:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mdu_iterative #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .operand_a    (a),
      .operand_b    (b),
      .flush        (flush),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .div_by_zero  (div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Called at posedge+1; issues start so that the next edge is E0.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res, input logic exp_dbz,
                         input int exp_lat);
      int lat = 0;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (result_valid) begin
            lat = i;
            break;
         end
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, result, exp_res);
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(result_valid), 32'd0);
      check({tag, "_hold"}, result, exp_res);
   endtask

   initial begin
      int nvalid;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul",    3'b000, 32'd2, 32'd4, 32'h0000_0008, 1'b0, 34);
      run_op("mul_n",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 34);
      run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 34);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("div",    3'b100, 32'd8, 32'd2, 32'h0000_0004, 1'b0, 34);
      run_op("div_n",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
      run_op("rem_n",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
      run_op("divu",   3'b101, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 1'b0, 34);
      run_op("divu_z", 3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
      run_op("remu_z", 3'b111, 32'h1234, 32'd0, 32'h0000_1234, 1'b1, 1);
      run_op("rem_z",  3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 1);
      run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 1'b0, 1);
      run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h0000_0000, 1'b0, 1);
      run_op("mul_pre", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 34);

      // flush mid-DIV: no result, previous result retained
      op = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("fl_busy_e0", 32'(busy), 32'd1);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      check("fl_busy", 32'(busy), 32'd0);
      nvalid = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (result_valid) nvalid++;
      end
      check("fl_novalid", 32'(nvalid), 32'd0);
      check("fl_result", result, 32'd42);

      // start while busy is ignored
      op = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nvalid = 0;
      for (int i = 1; i <= 100; i++) begin
         if (i == 5) begin
            op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
         end
         if (i == 6) start = 1'b0;
         @(posedge clk); #1;
         if (result_valid) begin
            nvalid = i;
            break;
         end
      end
      check("bz_lat", 32'(nvalid), 32'd34);
      check("bz_res", result, 32'd14);
      nvalid = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (result_valid || busy) nvalid++;
      end
      check("bz_ignored", 32'(nvalid), 32'd0);
      check("bz_hold", result, 32'd14);

      // asynchronous reset mid-DIV
      op = 3'b101; a = 32'd1000; b = 32'd10; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_result", result, 32'd0);
      check("ar_valid", 32'(result_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b0, 34);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
